// File: rtl/int_sched.sv
// Interrupt scheduler for the execute stage: captures request edges, applies
// mask and fixed priority, injects one-hot vectors and tracks nesting via RET.
module int_sched #(
    parameter int unsigned MAX_NEST  = 4,
    parameter logic [2:0]  ST_BRANCH = 3'd5,
    parameter logic [4:0]  OP_RET    = 5'b01110
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] IRQ_REQ,
    input  logic       MASK_WE,
    input  logic [3:0] MASK_IN,
    input  logic       GLOBAL_EN,
    input  logic [2:0] STAGE_STATE,
    input  logic [4:0] OPCD_IN,
    output logic [3:0] INTERRUPT,
    output logic [3:0] PENDING,
    output logic [3:0] IN_SERVICE,
    output logic [2:0] NEST_DEPTH,
    output logic       RET_UNDERFLOW
);

    logic [3:0] prev;
    logic [3:0] mask;
    logic [3:0] pending_q;
    logic [3:0] in_service_q;
    logic [2:0] depth_q;
    logic       underflow_q;
    logic       in_branch_q;
    logic [1:0] id_stack [MAX_NEST];

    logic       slot;
    logic       ret;
    logic       accept;
    logic       preempt_ok;
    logic       depth_ok;
    logic [3:0] edges;
    logic [3:0] eligible;
    logic [3:0] win_onehot;
    logic [3:0] isv_low;
    logic [3:0] pop_mask;
    logic [1:0] win_id;
    logic [1:0] top_id;

    // Only the first cycle of a BRANCH_JUMP visit is a slot, so a stage that
    // lingers in that state still sees a single evaluation per pass.
    assign slot  = RST && (STAGE_STATE == ST_BRANCH) && !in_branch_q;
    assign ret   = slot && (OPCD_IN == OP_RET);
    assign edges = IRQ_REQ & ~prev;

    assign eligible   = GLOBAL_EN ? (pending_q & mask) : '0;
    assign win_onehot = eligible & (~eligible + 4'd1);
    assign isv_low    = in_service_q & (~in_service_q + 4'd1);

    // Both operands are one-hot, so a lower index is a numerically smaller value.
    assign preempt_ok = (in_service_q == '0) || (win_onehot < isv_low);
    assign depth_ok   = 32'(depth_q) < MAX_NEST;
    assign accept     = slot && !ret && (eligible != '0) && preempt_ok && depth_ok;

    always_comb begin
        win_id = '0;
        case (win_onehot)
            4'b0010: win_id = 2'd1;
            4'b0100: win_id = 2'd2;
            4'b1000: win_id = 2'd3;
            default: win_id = 2'd0;
        endcase
    end

    always_comb begin
        top_id = '0;
        for (int unsigned i = 0; i < MAX_NEST; i++) begin
            if (32'(depth_q) == i + 1) begin
                top_id = id_stack[i];
            end
        end
    end

    assign pop_mask = 4'b0001 << top_id;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            prev         <= '0;
            mask         <= '1;
            pending_q    <= '0;
            in_service_q <= '0;
            depth_q      <= '0;
            underflow_q  <= 1'b0;
            in_branch_q  <= 1'b0;
            for (int unsigned i = 0; i < MAX_NEST; i++) begin
                id_stack[i] <= '0;
            end
        end else begin
            prev        <= IRQ_REQ;
            in_branch_q <= (STAGE_STATE == ST_BRANCH);
            if (MASK_WE) begin
                mask <= MASK_IN;
            end
            // A new edge in the acceptance cycle re-arms the bit.
            pending_q <= (pending_q & ~INTERRUPT) | edges;
            if (accept) begin
                in_service_q <= in_service_q | win_onehot;
                depth_q      <= depth_q + 3'd1;
                for (int unsigned i = 0; i < MAX_NEST; i++) begin
                    if (32'(depth_q) == i) begin
                        id_stack[i] <= win_id;
                    end
                end
            end else if (ret) begin
                if (depth_q != '0) begin
                    in_service_q <= in_service_q & ~pop_mask;
                    depth_q      <= depth_q - 3'd1;
                end else begin
                    underflow_q <= 1'b1;
                end
            end
        end
    end

    assign INTERRUPT     = accept ? win_onehot : '0;
    assign PENDING       = pending_q;
    assign IN_SERVICE    = in_service_q;
    assign NEST_DEPTH    = depth_q;
    assign RET_UNDERFLOW = underflow_q;

endmodule

// File: tb/tb_int_sched.sv
// Scoreboard bench for int_sched: a default instance and a MAX_NEST=2 instance
// share stimulus; expected injection pairs are queued per slot.
module tb_int_sched;

    localparam logic [4:0] NOP = 5'b00000;
    localparam logic [4:0] RET = 5'b01110;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] IRQ_REQ;
    logic       MASK_WE;
    logic [3:0] MASK_IN;
    logic       GLOBAL_EN;
    logic [2:0] STAGE_STATE;
    logic [4:0] OPCD_IN;

    logic [3:0] int1, pend1, isv1, int2, pend2, isv2;
    logic [2:0] depth1, depth2;
    logic       uf1, uf2;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [7:0]  sb [$];

    always #5 CLK = ~CLK;

    int_sched dut (
        .CLK(CLK), .RST(RST), .IRQ_REQ(IRQ_REQ), .MASK_WE(MASK_WE),
        .MASK_IN(MASK_IN), .GLOBAL_EN(GLOBAL_EN), .STAGE_STATE(STAGE_STATE),
        .OPCD_IN(OPCD_IN), .INTERRUPT(int1), .PENDING(pend1),
        .IN_SERVICE(isv1), .NEST_DEPTH(depth1), .RET_UNDERFLOW(uf1)
    );

    int_sched #(.MAX_NEST(2)) dut2 (
        .CLK(CLK), .RST(RST), .IRQ_REQ(IRQ_REQ), .MASK_WE(MASK_WE),
        .MASK_IN(MASK_IN), .GLOBAL_EN(GLOBAL_EN), .STAGE_STATE(STAGE_STATE),
        .OPCD_IN(OPCD_IN), .INTERRUPT(int2), .PENDING(pend2),
        .IN_SERVICE(isv2), .NEST_DEPTH(depth2), .RET_UNDERFLOW(uf2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse(input logic [3:0] bits);
        IRQ_REQ = bits;
        tick();
        IRQ_REQ = '0;
        tick();
    endtask

    // exp = {dut2 vector, dut vector}
    task automatic do_slot(input logic [4:0] op, input logic [7:0] exp);
        sb.push_back(exp);
        STAGE_STATE = 3'd5;
        OPCD_IN     = op;
        tick();
        STAGE_STATE = 3'd0;
        OPCD_IN     = NOP;
        tick();
    endtask

    task automatic write_mask(input logic [3:0] m);
        MASK_WE = 1'b1;
        MASK_IN = m;
        tick();
        MASK_WE = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        tick();
        tick();
        RST = 1'b1;
    endtask

    always @(negedge CLK) begin
        if (STAGE_STATE == 3'd5) begin
            if (sb.size() == 0) begin
                check("sb_underrun", 32'd1, 32'd0);
            end else begin
                check("slot_int", {int2, int1}, sb.pop_front());
            end
        end else begin
            check("idle_int", {int2, int1}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b0; IRQ_REQ = '0; MASK_WE = 1'b0; MASK_IN = '0;
        GLOBAL_EN = 1'b1; STAGE_STATE = 3'd0; OPCD_IN = NOP;
        do_reset();
        check("rst_pend", {pend2, pend1}, 32'h00);
        check("rst_isv", {isv2, isv1}, 32'h00);
        check("rst_depth", {depth2, depth1}, 32'h00);
        check("rst_uf", {uf2, uf1}, 32'h0);

        // single request
        pulse(4'b0100);
        check("t1_pend_set", pend1, 32'h4);
        do_slot(NOP, 8'h44);
        check("t1_pend", pend1, 32'h0);
        check("t1_isv", isv1, 32'h4);
        check("t1_depth", depth1, 32'd1);
        do_slot(RET, 8'h00);
        check("t1_ret_isv", isv1, 32'h0);

        // two simultaneous edges, RET then lower priority served
        pulse(4'b1010);
        do_slot(NOP, 8'h22);
        check("t2_pend", pend1, 32'h8);
        check("t2_isv", isv1, 32'h2);
        do_slot(RET, 8'h00);
        check("t2_ret_isv", isv1, 32'h0);
        do_slot(NOP, 8'h88);
        do_slot(RET, 8'h00);

        // nesting and blocking by in-service priority
        pulse(4'b0100);
        do_slot(NOP, 8'h44);
        pulse(4'b0001);
        do_slot(NOP, 8'h11);
        check("t3_depth", {depth2, depth1}, {3'd2, 3'd2});
        pulse(4'b1000);
        do_slot(NOP, 8'h00);
        do_slot(RET, 8'h00);
        check("t3_isv_pop", isv1, 32'h4);
        do_slot(NOP, 8'h00);
        do_slot(RET, 8'h00);
        check("t3_depth0", depth1, 32'd0);
        do_slot(NOP, 8'h88);
        do_slot(RET, 8'h00);

        // RET and eligible winner in the same slot
        pulse(4'b0100);
        do_slot(NOP, 8'h44);
        pulse(4'b0001);
        do_slot(RET, 8'h00);
        check("sim_isv", isv1, 32'h0);
        check("sim_pend", pend1, 32'h1);
        do_slot(NOP, 8'h11);
        do_slot(RET, 8'h00);

        // new edge in the acceptance cycle keeps the bit pending
        pulse(4'b0010);
        sb.push_back(8'h22);
        STAGE_STATE = 3'd5;
        IRQ_REQ = 4'b0010;
        tick();
        STAGE_STATE = 3'd0;
        IRQ_REQ = '0;
        tick();
        check("setwin_pend", pend1, 32'h2);
        check("setwin_isv", isv1, 32'h2);
        do_slot(RET, 8'h00);
        do_slot(NOP, 8'h22);
        do_slot(RET, 8'h00);

        // mask and global enable
        write_mask(4'b1110);
        pulse(4'b0001);
        do_slot(NOP, 8'h00);
        check("t4_pend_masked", pend1, 32'h1);
        write_mask(4'b1111);
        // mask write during a slot: old mask still applies
        sb.push_back(8'h11);
        MASK_WE = 1'b1;
        MASK_IN = 4'b1110;
        STAGE_STATE = 3'd5;
        tick();
        MASK_WE = 1'b0;
        STAGE_STATE = 3'd0;
        tick();
        do_slot(RET, 8'h00);
        write_mask(4'b1111);
        GLOBAL_EN = 1'b0;
        pulse(4'b0001);
        do_slot(NOP, 8'h00);
        check("t4_pend_gen", pend1, 32'h1);
        GLOBAL_EN = 1'b1;
        do_slot(NOP, 8'h11);
        do_slot(RET, 8'h00);

        // underflow
        check("t5_depth_pre", {depth2, depth1}, 32'h00);
        do_slot(RET, 8'h00);
        check("t5_uf", {uf2, uf1}, 32'h3);
        check("t5_depth", {depth2, depth1}, 32'h00);
        do_reset();
        check("t5_uf_rst", {uf2, uf1}, 32'h0);

        // depth limit on the MAX_NEST=2 instance
        pulse(4'b1000);
        do_slot(NOP, 8'h88);
        pulse(4'b0100);
        do_slot(NOP, 8'h44);
        pulse(4'b0001);
        do_slot(NOP, 8'h01);
        check("t6_pend2", pend2, 32'h1);
        check("t6_depth", {depth2, depth1}, {3'd2, 3'd3});
        do_slot(RET, 8'h00);
        do_slot(NOP, 8'h10);
        check("t6_isv2", isv2, 32'h9);

        // reset right after an injection
        do_reset();
        write_mask(4'b1110);
        pulse(4'b0010);
        sb.push_back(8'h22);
        STAGE_STATE = 3'd5;
        tick();
        STAGE_STATE = 3'd0;
        RST = 1'b0;
        tick();
        RST = 1'b1;
        check("t6_rst_pend", {pend2, pend1}, 32'h00);
        check("t6_rst_isv", {isv2, isv1}, 32'h00);
        check("t6_rst_depth", {depth2, depth1}, 32'h00);
        pulse(4'b0001);
        do_slot(NOP, 8'h11);

        check("sb_left", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
